// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data-memory access, stack pointer, CALL/RET sequencing
// Registers the MEM/WB fields and the RET target.
module mem_stage #(
  parameter int                ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] SP_RESET = 11'h7FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MRIn,
  input  logic              MWIn,
  input  logic              MTRIn,
  input  logic              RWIn,
  input  logic [15:0]       aluOutIn,
  input  logic [15:0]       read_data2In,
  input  logic [2:0]        RegDestinationIn,
  input  logic [1:0]        enablePushOrPopIn,
  input  logic [1:0]        firstTimeCallIn,
  input  logic [1:0]        firstTimeRETIn,
  input  logic [31:0]       pcIn,
  input  logic [3:0]        CCRIn,
  input  logic [15:0]       memRData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWData,
  output logic              memWE,
  output logic              memRE,
  output logic              stall,
  output logic [15:0]       wbData,
  output logic [2:0]        wbDest,
  output logic              wbEn,
  output logic [3:0]        CCROut,
  output logic [31:0]       retPC,
  output logic              retValid,
  output logic [ADDR_W-1:0] SP
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALL2 = 2'd1;
  localparam logic [1:0] ST_RET2  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       pc_lo_q, pc_lo_d;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [2:0]        wb_dest_q, wb_dest_d;
  logic              wb_en_q, wb_en_d;
  logic [3:0]        ccr_q, ccr_d;
  logic [31:0]       ret_pc_q, ret_pc_d;
  logic              ret_valid_q, ret_valid_d;

  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;
  logic              is_pop;
  logic              in_xfer;

  assign sp_inc = sp_q + ADDR_W'(1);
  assign sp_dec = sp_q - ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pc_lo_d     = pc_lo_q;
    ret_pc_d    = ret_pc_q;
    ret_valid_d = 1'b0;
    memAddr     = aluOutIn[ADDR_W-1:0];
    memWData    = read_data2In;
    memWE       = 1'b0;
    memRE       = 1'b0;
    stall       = 1'b0;
    is_pop      = 1'b0;
    in_xfer     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (firstTimeCallIn == 2'b01) begin
          // High half goes first so the low half ends up nearest the top.
          memAddr  = sp_q;
          memWData = pcIn[31:16];
          memWE    = 1'b1;
          sp_d     = sp_dec;
          pc_lo_d  = pcIn[15:0];
          stall    = 1'b1;
          state_d  = ST_CALL2;
        end else if (firstTimeRETIn == 2'b01) begin
          memAddr = sp_inc;
          memRE   = 1'b1;
          sp_d    = sp_inc;
          pc_lo_d = memRData;
          stall   = 1'b1;
          state_d = ST_RET2;
        end else if (enablePushOrPopIn == 2'b01) begin
          memAddr = sp_q;
          memWE   = 1'b1;
          sp_d    = sp_dec;
        end else if (enablePushOrPopIn == 2'b10) begin
          memAddr = sp_inc;
          memRE   = 1'b1;
          sp_d    = sp_inc;
          is_pop  = 1'b1;
        end else begin
          memWE = MWIn;
          memRE = MRIn;
        end
      end
      ST_CALL2: begin
        memAddr  = sp_q;
        memWData = pc_lo_q;
        memWE    = 1'b1;
        sp_d     = sp_dec;
        in_xfer  = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_RET2: begin
        memAddr     = sp_inc;
        memRE       = 1'b1;
        sp_d        = sp_inc;
        ret_pc_d    = {memRData, pc_lo_q};
        ret_valid_d = 1'b1;
        in_xfer     = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      memWE = 1'b0;
      memRE = 1'b0;
      stall = 1'b0;
    end
    wb_data_d = (MTRIn || is_pop) ? memRData : aluOutIn;
    wb_dest_d = RegDestinationIn;
    wb_en_d   = RWIn && !in_xfer;
    ccr_d     = CCRIn;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sp_q        <= SP_RESET;
      pc_lo_q     <= '0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_en_q     <= 1'b0;
      ccr_q       <= '0;
      ret_pc_q    <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pc_lo_q     <= pc_lo_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_en_q     <= wb_en_d;
      ccr_q       <= ccr_d;
      ret_pc_q    <= ret_pc_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  assign wbData   = wb_data_q;
  assign wbDest   = wb_dest_q;
  assign wbEn     = wb_en_q;
  assign CCROut   = ccr_q;
  assign retPC    = ret_pc_q;
  assign retValid = ret_valid_q;
  assign SP       = sp_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with two SP_RESET settings
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mr, mw, mtr, rw;
  logic [15:0] alu, rd2;
  logic [2:0]  dest;
  logic [1:0]  pp, ftc, ftr;
  logic [31:0] pc;
  logic [3:0]  ccr;

  logic [10:0] mem_addr_a, sp_a, mem_addr_b, sp_b;
  logic [15:0] mem_wdata_a, mem_rdata_a, wb_data_a;
  logic [15:0] mem_wdata_b, mem_rdata_b, wb_data_b;
  logic        mem_we_a, mem_re_a, stall_a, wb_en_a, ret_valid_a;
  logic        mem_we_b, mem_re_b, stall_b, wb_en_b, ret_valid_b;
  logic [2:0]  wb_dest_a, wb_dest_b;
  logic [3:0]  ccr_out_a, ccr_out_b;
  logic [31:0] ret_pc_a, ret_pc_b;

  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];

  int checks;
  int errors;

  mem_stage dut_a (
    .clk(clk), .rst(rst), .MRIn(mr), .MWIn(mw), .MTRIn(mtr), .RWIn(rw),
    .aluOutIn(alu), .read_data2In(rd2), .RegDestinationIn(dest),
    .enablePushOrPopIn(pp), .firstTimeCallIn(ftc), .firstTimeRETIn(ftr),
    .pcIn(pc), .CCRIn(ccr), .memRData(mem_rdata_a),
    .memAddr(mem_addr_a), .memWData(mem_wdata_a), .memWE(mem_we_a), .memRE(mem_re_a),
    .stall(stall_a), .wbData(wb_data_a), .wbDest(wb_dest_a), .wbEn(wb_en_a),
    .CCROut(ccr_out_a), .retPC(ret_pc_a), .retValid(ret_valid_a), .SP(sp_a)
  );

  mem_stage #(.ADDR_W(11), .SP_RESET(11'h000)) dut_b (
    .clk(clk), .rst(rst), .MRIn(mr), .MWIn(mw), .MTRIn(mtr), .RWIn(rw),
    .aluOutIn(alu), .read_data2In(rd2), .RegDestinationIn(dest),
    .enablePushOrPopIn(pp), .firstTimeCallIn(ftc), .firstTimeRETIn(ftr),
    .pcIn(pc), .CCRIn(ccr), .memRData(mem_rdata_b),
    .memAddr(mem_addr_b), .memWData(mem_wdata_b), .memWE(mem_we_b), .memRE(mem_re_b),
    .stall(stall_b), .wbData(wb_data_b), .wbDest(wb_dest_b), .wbEn(wb_en_b),
    .CCROut(ccr_out_b), .retPC(ret_pc_b), .retValid(ret_valid_b), .SP(sp_b)
  );

  assign mem_rdata_a = mem_a[mem_addr_a];
  assign mem_rdata_b = mem_b[mem_addr_b];

  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
    if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    mr = 0; mw = 0; mtr = 0; rw = 0;
    alu = 0; rd2 = 0; dest = 0;
    pp = 0; ftc = 0; ftr = 0;
    pc = 0; ccr = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1;
    tick();
    // Strobes must stay low during reset even with requests present
    mw = 1; ftc = 2'b01;
    #1;
    check_eq("rst_we", mem_we_a, 0);
    check_eq("rst_re", mem_re_a, 0);
    check_eq("rst_stall", stall_a, 0);
    tick();
    clear_inputs();
    rst = 0;
    #1;
    check_eq("rst_sp_a", sp_a, 11'h7FF);
    check_eq("rst_sp_b", sp_b, 11'h000);
    check_eq("rst_wb", {wb_data_a, 13'(wb_dest_a), 3'(wb_en_a)}, 0);
    check_eq("rst_ccr", ccr_out_a, 0);
    check_eq("rst_retpc", ret_pc_a, 0);
    check_eq("rst_retv", ret_valid_a, 0);

    // Store then load
    alu = 16'h0010; rd2 = 16'hBEEF; mw = 1;
    #1;
    check_eq("st_addr", mem_addr_a, 11'h010);
    check_eq("st_we", mem_we_a, 1);
    tick();
    clear_inputs();
    alu = 16'h0010; mr = 1; mtr = 1; rw = 1; dest = 3'd5; ccr = 4'h5;
    #1;
    check_eq("ld_re", mem_re_a, 1);
    tick();
    check_eq("ld_data", wb_data_a, 16'hBEEF);
    check_eq("ld_dest", wb_dest_a, 5);
    check_eq("ld_en", wb_en_a, 1);
    check_eq("ld_ccr", ccr_out_a, 4'h5);

    // Push with a competing store: stack op wins
    clear_inputs();
    pp = 2'b01; rd2 = 16'h1234; mw = 1; alu = 16'h0020;
    #1;
    check_eq("push_addr", mem_addr_a, 11'h7FF);
    check_eq("push_we", mem_we_a, 1);
    check_eq("push_addr_b", mem_addr_b, 11'h000);
    tick();
    check_eq("push_sp", sp_a, 11'h7FE);
    check_eq("push_mem", mem_a[11'h7FF], 16'h1234);
    check_eq("wrap_push_sp", sp_b, 11'h7FF);
    check_eq("wrap_push_mem", mem_b[11'h000], 16'h1234);

    clear_inputs();
    pp = 2'b10; dest = 3'd2; rw = 1; alu = 16'h5555;
    #1;
    check_eq("pop_addr", mem_addr_a, 11'h7FF);
    check_eq("pop_re", mem_re_a, 1);
    check_eq("wrap_pop_addr", mem_addr_b, 11'h000);
    tick();
    check_eq("pop_data", wb_data_a, 16'h1234);
    check_eq("pop_dest", wb_dest_a, 2);
    check_eq("pop_sp", sp_a, 11'h7FF);
    check_eq("wrap_pop_data", wb_data_b, 16'h1234);
    check_eq("wrap_pop_sp", sp_b, 11'h000);

    // CALL with a simultaneous RET start: CALL wins
    clear_inputs();
    ftc = 2'b01; ftr = 2'b01; pc = 32'h0001_00A0;
    #1;
    check_eq("call1_stall", stall_a, 1);
    check_eq("call1_addr", mem_addr_a, 11'h7FF);
    check_eq("call1_wdata", mem_wdata_a, 16'h0001);
    check_eq("call1_we", mem_we_a, 1);
    tick();
    clear_inputs();
    rw = 1; mw = 1; alu = 16'h0040;
    #1;
    check_eq("call2_stall", stall_a, 0);
    check_eq("call2_addr", mem_addr_a, 11'h7FE);
    check_eq("call2_wdata", mem_wdata_a, 16'h00A0);
    tick();
    check_eq("call2_wben", wb_en_a, 0);
    check_eq("call_sp", sp_a, 11'h7FD);
    check_eq("call_hi", mem_a[11'h7FF], 16'h0001);
    check_eq("call_lo", mem_a[11'h7FE], 16'h00A0);

    // RET right after the CALL
    clear_inputs();
    ftr = 2'b01;
    #1;
    check_eq("ret1_stall", stall_a, 1);
    check_eq("ret1_addr", mem_addr_a, 11'h7FE);
    check_eq("ret1_re", mem_re_a, 1);
    tick();
    check_eq("ret1_sp", sp_a, 11'h7FE);
    check_eq("ret1_wben", wb_en_a, 0);
    clear_inputs();
    rw = 1;
    #1;
    check_eq("ret2_addr", mem_addr_a, 11'h7FF);
    check_eq("ret2_re", mem_re_a, 1);
    tick();
    clear_inputs();
    check_eq("ret_pc", ret_pc_a, 32'h0001_00A0);
    check_eq("ret_valid", ret_valid_a, 1);
    check_eq("ret_sp", sp_a, 11'h7FF);
    check_eq("ret2_wben", wb_en_a, 0);
    tick();
    check_eq("ret_valid_off", ret_valid_a, 0);

    // Reset during CALL2 abandons the second write
    ftc = 2'b01; pc = 32'h0002_1111; ccr = 4'hA; rw = 1; dest = 3'd6; alu = 16'h7777;
    tick();
    check_eq("call_b4rst_ccr", ccr_out_a, 4'hA);
    clear_inputs();
    rst = 1;
    #1;
    check_eq("rst_call2_we", mem_we_a, 0);
    check_eq("rst_call2_stall", stall_a, 0);
    tick();
    rst = 0;
    check_eq("rstc_sp", sp_a, 11'h7FF);
    check_eq("rstc_mem", mem_a[11'h7FE], 16'h00A0);
    check_eq("rstc_hi", mem_a[11'h7FF], 16'h0002);
    check_eq("rstc_wbdata", wb_data_a, 0);
    check_eq("rstc_wbdest", wb_dest_a, 0);
    check_eq("rstc_wben", wb_en_a, 0);
    check_eq("rstc_ccr", ccr_out_a, 0);
    check_eq("rstc_retpc", ret_pc_a, 0);
    check_eq("rstc_retv", ret_valid_a, 0);
    mw = 1; alu = 16'h0030;
    #1;
    check_eq("rstc_idle_addr", mem_addr_a, 11'h030);
    tick();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
